inst_loader: RTL and testbench

- Upstream stage of the CPU core: turns the raw UART receive byte stream into 32-bit instruction words and writes them into instruction memory before execution starts.
- Waits for a sync byte, assembles bytes MSB-first into words, and writes each word at consecutive word addresses.
- Stops on an all-zero terminator word and raises load_done, which the core uses as its go signal for execution.
- Framing errors and memory overflow are reported instead of silently corrupting the program.

---
 rtl/inst_loader.sv | 127 ++++++++++++
 tb/tb_inst_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - UART byte stream to instruction memory loader
module inst_loader #(
  parameter int         INST_SIZE = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_ferr,
  input  logic                 load_restart,
  output logic                 imem_we,
  output logic [INST_SIZE-1:0] imem_addr,
  output logic [31:0]          imem_wdata,
  output logic [INST_SIZE:0]   word_count,
  output logic                 load_done,
  output logic                 load_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

  localparam logic [INST_SIZE:0] CNT_ONE = {{INST_SIZE{1'b0}}, 1'b1};

  state_t                 state, state_n;
  logic [1:0]             byte_idx, byte_idx_n;
  logic [31:0]            asm_word, asm_word_n;
  logic [31:0]            word_in;
  logic                   we_n;
  logic [INST_SIZE-1:0]   addr_n;
  logic [31:0]            wdata_n;
  logic [INST_SIZE:0]     count_n;
  logic                   last_slot;

  // The address about to be written is the last one; a nonzero word there leaves no room for a terminator
  assign last_slot = &word_count[INST_SIZE-1:0];

  // Drop the incoming byte into its MSB-first lane of the assembly word
  always_comb begin
    word_in = asm_word;
    case (byte_idx)
      2'd0: word_in[31:24] = rx_data;
      2'd1: word_in[23:16] = rx_data;
      2'd2: word_in[15:8]  = rx_data;
      2'd3: word_in[7:0]   = rx_data;
    endcase
  end

  // Next-state and next-output decision; restart outranks any byte in the same cycle
  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    asm_word_n = asm_word;
    we_n       = 1'b0;
    addr_n     = imem_addr;
    wdata_n    = imem_wdata;
    count_n    = word_count;

    if (load_restart) begin
      state_n    = S_IDLE;
      byte_idx_n = 2'd0;
      asm_word_n = 32'd0;
      count_n    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_valid && !rx_ferr && rx_data == SYNC_BYTE) begin
            state_n    = S_LOAD;
            byte_idx_n = 2'd0;
          end
        end
        S_LOAD: begin
          if (rx_valid) begin
            if (rx_ferr) begin
              // Partial word is thrown away; nothing reaches memory
              state_n    = S_ERROR;
              byte_idx_n = 2'd0;
              asm_word_n = 32'd0;
            end else begin
              asm_word_n = word_in;
              byte_idx_n = byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                // Write pulse lands in the cycle after the 4th byte strobe
                we_n    = 1'b1;
                addr_n  = word_count[INST_SIZE-1:0];
                wdata_n = word_in;
                count_n = word_count + CNT_ONE;
                if (word_in == 32'd0)
                  state_n = S_DONE;
                else if (last_slot)
                  state_n = S_ERROR;
              end
            end
          end
        end
        S_DONE:  ;
        S_ERROR: ;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Register state and all outputs so flags and memory strobes are glitch-free
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_idx   <= 2'd0;
      asm_word   <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      word_count <= '0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      byte_idx   <= byte_idx_n;
      asm_word   <= asm_word_n;
      imem_we    <= we_n;
      imem_addr  <= addr_n;
      imem_wdata <= wdata_n;
      word_count <= count_n;
      load_done  <= (state_n == S_DONE);
      load_err   <= (state_n == S_ERROR);
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - randomized self-checking bench for inst_loader
module tb_inst_loader;

  localparam int IS = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ferr = 1'b0;
  logic          load_restart = 1'b0;
  logic          imem_we;
  logic [IS-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [IS:0]   word_count;
  logic          load_done;
  logic          load_err;

  inst_loader #(.INST_SIZE(IS), .SYNC_BYTE(8'hAA)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .load_restart(load_restart), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .word_count(word_count), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // stimulus log: byte, framing flag, time of the capturing edge
  logic [7:0]  s_data[$];
  logic        s_ferr[$];
  logic [31:0] s_time[$];
  // observed writes
  logic [31:0] w_addr[$];
  logic [31:0] w_data[$];
  logic [31:0] w_time[$];

  // Record every write pulse seen mid-cycle
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      w_addr.push_back(32'(imem_addr));
      w_data.push_back(imem_wdata);
      w_time.push_back(32'($time));
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    s_data.delete(); s_ferr.delete(); s_time.delete();
    w_addr.delete(); w_data.delete(); w_time.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic f, input int gap);
    @(posedge clk); #1;
    rx_data = d; rx_valid = 1'b1; rx_ferr = f;
    @(posedge clk);
    s_data.push_back(d); s_ferr.push_back(f); s_time.push_back(32'($time));
    #1;
    rx_valid = 1'b0; rx_ferr = 1'b0; rx_data = 8'($urandom);
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], 1'b0, $urandom_range(0, 2));
  endtask

  task automatic restart();
    @(posedge clk); #1 load_restart = 1'b1;
    @(posedge clk); #1 load_restart = 1'b0;
    clear_logs();
  endtask

  // Reference: walk the byte log with the loader's rules and compare everything observed
  task automatic evaluate(input string name);
    logic [31:0] e_addr[$];
    logic [31:0] e_data[$];
    logic [31:0] e_time[$];
    logic [7:0]  part[$];
    logic [31:0] w;
    int cnt = 0;
    bit armed = 0, done = 0, err = 0;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    foreach (s_data[i]) begin
      if (done || err) continue;
      if (!armed) begin
        if (!s_ferr[i] && s_data[i] == 8'hAA) armed = 1;
        continue;
      end
      if (s_ferr[i]) begin err = 1; continue; end
      part.push_back(s_data[i]);
      if (part.size() == 4) begin
        w = {part[0], part[1], part[2], part[3]};
        part.delete();
        e_addr.push_back(32'(cnt)); e_data.push_back(w); e_time.push_back(s_time[i] + 32'd5);
        cnt++;
        if (w == 32'd0) done = 1;
        else if (cnt == (1 << IS)) err = 1;
      end
    end
    check_eq({name, ".nwrites"}, 32'(w_data.size()), 32'(e_data.size()));
    n = (w_data.size() < e_data.size()) ? w_data.size() : e_data.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s.addr%0d", name, i), w_addr[i], e_addr[i]);
      check_eq($sformatf("%s.data%0d", name, i), w_data[i], e_data[i]);
      check_eq($sformatf("%s.time%0d", name, i), w_time[i], e_time[i]);
    end
    check_eq({name, ".word_count"}, 32'(word_count), 32'(cnt));
    check_eq({name, ".load_done"}, 32'(load_done), 32'(done));
    check_eq({name, ".load_err"}, 32'(load_err), 32'(err));
    if (e_data.size() > 0) begin
      check_eq({name, ".addr_hold"}, 32'(imem_addr), e_addr[e_addr.size()-1]);
      check_eq({name, ".wdata_hold"}, imem_wdata, e_data[e_data.size()-1]);
    end
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, ".we"}, 32'(imem_we), 32'd0);
    check_eq({name, ".addr"}, 32'(imem_addr), 32'd0);
    check_eq({name, ".wdata"}, imem_wdata, 32'd0);
    check_eq({name, ".count"}, 32'(word_count), 32'd0);
    check_eq({name, ".done"}, 32'(load_done), 32'd0);
    check_eq({name, ".err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int nw;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // program load
    clear_logs();
    send_byte(8'hAA, 1'b0, 1);
    send_word(32'h00000001); send_word(32'h12345678); send_word(32'h00000000);
    evaluate("program");
    check_eq("program.count3", 32'(word_count), 32'd3);

    // pre-sync noise
    restart();
    send_byte(8'h55, 1'b0, 1); send_byte(8'hFF, 1'b0, 1); send_byte(8'h00, 1'b0, 1);
    send_byte(8'hAA, 1'b0, 1); send_word(32'h0);
    evaluate("noise");

    // framing error, then clean reload
    restart();
    send_byte(8'hAA, 1'b0, 1); send_byte(8'hDE, 1'b0, 1); send_byte(8'hAD, 1'b0, 1);
    send_byte(8'hBE, 1'b1, 1);
    evaluate("ferr");
    restart();
    send_byte(8'hAA, 1'b0, 1); send_word(32'hCAFE0005); send_word(32'h0);
    evaluate("ferr_reload");

    // overflow and exact fit
    restart();
    send_byte(8'hAA, 1'b0, 1);
    for (int i = 1; i <= 4; i++) send_word(32'h01010101 * i);
    evaluate("overflow");
    restart();
    send_byte(8'hAA, 1'b0, 1);
    for (int i = 1; i <= 3; i++) send_word(32'h0A0B0C00 + i);
    send_word(32'h0);
    evaluate("fit");

    // restart mid-load
    restart();
    send_byte(8'hAA, 1'b0, 1); send_word(32'h11223344);
    send_byte(8'h55, 1'b0, 1); send_byte(8'h66, 1'b0, 1);
    @(posedge clk); #1 load_restart = 1'b1;
    @(posedge clk); #1 load_restart = 1'b0;
    send_byte(8'h77, 1'b0, 0); send_byte(8'h88, 1'b0, 0);
    send_byte(8'h99, 1'b0, 0); send_byte(8'h00, 1'b0, 3);
    @(negedge clk);
    check_eq("midrst.nwrites", 32'(w_data.size()), 32'd1);
    check_eq("midrst.count", 32'(word_count), 32'd0);
    check_eq("midrst.flags", 32'({load_done, load_err}), 32'd0);

    // async reset mid-byte
    restart();
    send_byte(8'hAA, 1'b0, 1); send_word(32'h11223344);
    send_byte(8'h55, 1'b0, 1); send_byte(8'h66, 1'b0, 1);
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h77;
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    rx_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    send_word(32'h0); send_byte(8'hAA, 1'b0, 1); send_word(32'h0);
    evaluate("after_rst");

    // restart coinciding with sync byte in IDLE
    restart();
    @(posedge clk); #1 load_restart = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    @(posedge clk); #1 load_restart = 1'b0; rx_valid = 1'b0;
    send_word(32'h0);
    evaluate("coincide");

    // bytes after DONE are ignored
    restart();
    send_byte(8'hAA, 1'b0, 1); send_word(32'h0);
    send_word(32'h01020304); send_byte(8'hAA, 1'b0, 1); send_word(32'h01020304);
    evaluate("done_hold");

    // randomized streams
    for (int it = 0; it < 30; it++) begin
      restart();
      repeat ($urandom_range(0, 3)) begin
        w = $urandom;
        send_byte((w[7:0] == 8'hAA) ? 8'h5A : w[7:0], w[8], $urandom_range(0, 2));
      end
      send_byte(8'hAA, 1'b0, $urandom_range(0, 2));
      nw = $urandom_range(0, 5);
      for (int k = 0; k < nw; k++) begin
        w = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
        if ($urandom_range(0, 9) == 0) send_byte(8'($urandom), 1'b1, 1);
        send_word(w);
      end
      if ($urandom_range(0, 1) == 1) send_word(32'h0);
      evaluate($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
